// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_seq divider sequencer.
//   state_t     : sequencer state (STOP, RUN, PEND)
//   PKG_CNT_W   : default counter/ratio width
//   PKG_DEF_DIV : default ratio loaded at reset
//   PKG_MIN_DIV : smallest legal ratio
//   half_hi(n)  : length of the high phase for ratio n, ceil(n/2)
package clk_div_pkg;

    localparam int unsigned PKG_CNT_W   = 4;
    localparam int unsigned PKG_DEF_DIV = 9;
    localparam int unsigned PKG_MIN_DIV = 2;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    function automatic int unsigned half_hi(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter of the divider: counts 0..cur_div-1 while running, flags the
// terminal count and produces the registered high phase of the divided clock.
//   clk, rst : clock, asynchronous active-high reset
//   run      : sequencer is counting this cycle
//   nxt_run  : sequencer will be counting next cycle
//   cur_div  : ratio in force this cycle
//   nxt_div  : ratio that will be in force next cycle
//   div_cnt  : phase counter
//   div_tc   : terminal count (combinational on div_cnt)
//   div_hi   : registered high phase, 1 for div_cnt < ceil(ratio/2)
module clk_div_phase_cnt
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = PKG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             nxt_run,
    input  logic [CNT_W-1:0] cur_div,
    input  logic [CNT_W-1:0] nxt_div,
    output logic [CNT_W-1:0] div_cnt,
    output logic             div_tc,
    output logic             div_hi
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hi_q, hi_d;

    always_comb begin
        div_tc = run && (cnt_q == (cur_div - ONE));
        // Restart at 0 on entry to counting, on wrap, and whenever stopped.
        cnt_d  = (run && nxt_run && !div_tc) ? (cnt_q + ONE) : '0;
        // Decoded from next-cycle count and ratio so div_hi is a clean flop output.
        hi_d   = nxt_run && (32'(cnt_d) < half_hi(32'(nxt_div)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
        end
    end

    assign div_cnt = cnt_q;
    assign div_hi  = hi_q;

endmodule

// File: rtl/clk_div_seq.sv
// Sequencer for the programmable odd/even clock divider. Accepts new ratios over
// a valid/ready handshake and applies them only on a period boundary so the
// divided clock never shows a runt pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : run request (level)
//   cfg_valid : new ratio offered
//   cfg_div   : requested ratio
//   cfg_ready : a ratio can be accepted
//   cfg_err   : one-cycle pulse, accepted ratio was below MIN_DIV
//   cur_div   : ratio in force
//   div_cnt   : phase counter 0..cur_div-1
//   div_tc    : terminal count
//   div_hi    : posedge-domain high phase
//   div_odd   : cur_div[0], enables the downstream negedge AND stage
//   running   : sequencer is not stopped
module clk_div_seq
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = PKG_CNT_W,
    parameter int unsigned DEF_DIV = PKG_DEF_DIV,
    parameter int unsigned MIN_DIV = PKG_MIN_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic [CNT_W-1:0] div_cnt,
    output logic             div_tc,
    output logic             div_hi,
    output logic             div_odd,
    output logic             running
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             err_q, err_d;
    logic             xfer, legal;
    logic             tc;

    assign cfg_ready = (state_q != PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (32'(cfg_div) >= MIN_DIV);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        err_d   = xfer && !legal;
        case (state_q)
            STOP: begin
                if (xfer && legal) div_d = cfg_div;
                if (en) state_d = RUN;
            end
            RUN: begin
                // A new ratio takes priority; a pending stop is re-evaluated at
                // the next tc since en is level-sensitive.
                if (xfer && legal) begin
                    pend_d  = cfg_div;
                    state_d = PEND;
                end else if (tc && !en) begin
                    state_d = STOP;
                end
            end
            PEND: begin
                if (tc) begin
                    div_d   = pend_q;
                    state_d = en ? RUN : STOP;
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STOP;
            div_q   <= CNT_W'(DEF_DIV);
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    clk_div_phase_cnt #(
        .CNT_W(CNT_W)
    ) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q != STOP),
        .nxt_run (state_d != STOP),
        .cur_div (div_q),
        .nxt_div (div_d),
        .div_cnt (div_cnt),
        .div_tc  (tc),
        .div_hi  (div_hi)
    );

    assign div_tc  = tc;
    assign cfg_err = err_q;
    assign cur_div = div_q;
    assign div_odd = div_q[0];
    assign running = (state_q != STOP);

endmodule
